// File: rtl/systema_pio_pkg.sv
// Shared definitions for the debounced PIO slave: register map and debounce
// counter width limit.
package systema_pio_pkg;

  localparam int unsigned DbWMax = 16;
  localparam int unsigned BusW   = 32;

  typedef enum logic [2:0] {
    RegData    = 3'd0,
    RegRaw     = 3'd1,
    RegIrqMask = 3'd2,
    RegEdgeCap = 3'd3,
    RegRiseEn  = 3'd4,
    RegFallEn  = 3'd5,
    RegDbLimit = 3'd6,
    RegRsvd    = 3'd7
  } reg_addr_e;

endpackage

// File: rtl/systema_debounce_ch.sv
// One input channel: two-flop synchronizer, debounce counter, debounced state
// and single-cycle rise/fall pulses aligned with the debounced-state change.
module systema_debounce_ch #(
  parameter int unsigned DB_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_bit,
  input  logic [DB_W-1:0] db_limit,
  output logic            data,
  output logic            sync,
  output logic            rise,
  output logic            fall
);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= in_bit;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so a limit lowered below a running count still commits.
  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    commit = 1'b0;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_limit) begin
      db_d   = s2_q;
      cnt_d  = '0;
      commit = 1'b1;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  assign data = db_q;
  assign sync = s2_q;
  assign rise = commit & s2_q;
  assign fall = commit & ~s2_q;

endmodule

// File: rtl/systema_debounced_input.sv
// Avalon-MM PIO slave with per-channel debouncing, edge capture with
// write-1-to-clear, and a masked level interrupt.
module systema_debounced_input
  import systema_pio_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DB_W     = 16,
  parameter int unsigned DB_RESET = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  reg_addr_e       addr;
  logic            wr_en;
  logic [WIDTH-1:0] data, sync, rise, fall;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] ec_clr;
  logic [DB_W-1:0]  db_limit_q, db_limit_d;
  logic [BusW-1:0]  readdata_d;
  logic             unused_wdata;

  assign addr         = reg_addr_e'(address);
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    systema_debounce_ch #(
      .DB_W(DB_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .in_bit  (in_port[i]),
      .db_limit(db_limit_q),
      .data    (data[i]),
      .sync    (sync[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    db_limit_d = db_limit_q;
    ec_clr     = '0;
    if (wr_en) begin
      case (addr)
        RegIrqMask: irq_mask_d = writedata[WIDTH-1:0];
        RegEdgeCap: ec_clr     = writedata[WIDTH-1:0];
        RegRiseEn:  rise_en_d  = writedata[WIDTH-1:0];
        RegFallEn:  fall_en_d  = writedata[WIDTH-1:0];
        RegDbLimit: db_limit_d = writedata[DB_W-1:0];
        default: ;
      endcase
    end
    // New events are ORed in after the clear so a coincident event survives.
    edge_cap_d = (edge_cap_q & ~ec_clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    readdata_d = '0;
    case (addr)
      RegData:    readdata_d[WIDTH-1:0] = data;
      RegRaw:     readdata_d[WIDTH-1:0] = sync;
      RegIrqMask: readdata_d[WIDTH-1:0] = irq_mask_q;
      RegEdgeCap: readdata_d[WIDTH-1:0] = edge_cap_q;
      RegRiseEn:  readdata_d[WIDTH-1:0] = rise_en_q;
      RegFallEn:  readdata_d[WIDTH-1:0] = fall_en_q;
      RegDbLimit: readdata_d[DB_W-1:0]  = db_limit_q;
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      db_limit_q <= DB_W'(DB_RESET);
      readdata   <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      db_limit_q <= db_limit_d;
      readdata   <= readdata_d;
    end
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_systema_debounced_input.sv
// Directed bench for systema_debounced_input: register access, debounce
// timing, edge capture/clear races, interrupt and reset behaviour.
module tb_systema_debounced_input;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int vec = 0;
  int err = 0;

  systema_debounced_input #(
    .WIDTH   (4),
    .DB_W    (16),
    .DB_RESET(0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp)
    else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'h0;
    #1;
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    rd_chk("reset_db_limit", 3'd6, 32'h0);
    rd_chk("reset_fall_en", 3'd5, 32'h0);
    rd_chk("addr7_reads_zero", 3'd7, 32'h0);

    // Setup; upper writedata bits must be ignored.
    wr(3'd6, 32'd4);
    wr(3'd4, 32'hFFFF_FFFF);
    wr(3'd2, 32'h1);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("rise_en_masked", 3'd4, 32'hF);
    rd_chk("db_limit_rw", 3'd6, 32'd4);
    rd_chk("addr7_write_ignored", 3'd7, 32'h0);

    // Stable rise on bit0: commit exactly 7 edges after the change.
    @(negedge clk);
    in_port[0] = 1'b1;
    address    = 3'd0;
    repeat (6) @(posedge clk);
    #1;
    chk("rise_irq_edge6", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    chk("rise_irq_edge7", {31'd0, irq}, 32'h1);
    @(posedge clk);
    #1;
    chk("rise_data_edge8", readdata, 32'h1);
    rd_chk("rise_edge_cap", 3'd3, 32'h1);
    rd_chk("raw_sync", 3'd1, 32'h1);

    wr(3'd3, 32'h1);
    chk("w1c_irq", {31'd0, irq}, 32'h0);
    rd_chk("w1c_edge_cap", 3'd3, 32'h0);

    // 4-cycle glitch on bit1 at limit 4 must be rejected.
    @(negedge clk);
    in_port[1] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (8) @(posedge clk);
    rd_chk("glitch_data", 3'd0, 32'h1);
    rd_chk("glitch_edge_cap", 3'd3, 32'h0);

    // Bit2 up, then falling edge with interrupt.
    @(negedge clk);
    in_port[2] = 1'b1;
    repeat (10) @(posedge clk);
    rd_chk("bit2_high_data", 3'd0, 32'h5);
    rd_chk("bit2_rise_cap", 3'd3, 32'h4);
    wr(3'd3, 32'h4);
    wr(3'd5, 32'h4);
    wr(3'd2, 32'h4);
    chk("fall_irq_before", {31'd0, irq}, 32'h0);
    @(negedge clk);
    in_port[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("fall_irq_set", {31'd0, irq}, 32'h1);
    rd_chk("fall_edge_cap", 3'd3, 32'h4);
    wr(3'd3, 32'h4);
    chk("fall_irq_cleared", {31'd0, irq}, 32'h0);

    // Clear of bit0 lands on the same edge bit0 falls: bit must stay set.
    wr(3'd5, 32'h5);
    @(negedge clk);
    in_port[0] = 1'b0;
    repeat (6) @(posedge clk);
    wr(3'd3, 32'h1);
    rd_chk("race_edge_cap", 3'd3, 32'h1);
    rd_chk("race_data", 3'd0, 32'h0);

    // Lowering db_limit mid-count commits on the next mismatching cycle.
    @(negedge clk);
    in_port[3] = 1'b1;
    repeat (3) @(posedge clk);
    wr(3'd6, 32'd1);
    address = 3'd0;
    @(posedge clk);
    #1;
    chk("midcount_before", readdata, 32'h0);
    @(posedge clk);
    #1;
    chk("midcount_commit", readdata, 32'h8);
    rd_chk("midcount_edge_cap", 3'd3, 32'h9);

    // Asynchronous reset mid-count.
    wr(3'd2, 32'hF);
    chk("pre_reset_irq", {31'd0, irq}, 32'h1);
    wr(3'd4, 32'h0);
    wr(3'd6, 32'd4);
    @(negedge clk);
    in_port = 4'hF;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", readdata, 32'h0);
    chk("async_rst_irq", {31'd0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_chk("rst_db_limit", 3'd6, 32'h0);
    rd_chk("rst_irq_mask", 3'd2, 32'h0);
    rd_chk("rst_rise_en", 3'd4, 32'h0);
    rd_chk("rst_fall_en", 3'd5, 32'h0);
    repeat (8) @(posedge clk);
    rd_chk("rst_no_spurious", 3'd3, 32'h0);
    rd_chk("rst_data_follows", 3'd0, 32'hF);
    chk("rst_irq_quiet", {31'd0, irq}, 32'h0);

    // Input held high through release, rise_en set before the commit.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr(3'd4, 32'hF);
    repeat (4) @(posedge clk);
    rd_chk("held_high_event", 3'd3, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/systema_debounced_input.md
SYSTEMA_DEBOUNCED_INPUT -- requirements
Module: systema_debounced_input

Interface
REQ-001 Parameter WIDTH, 4, number of input channels, legal range 1..32, SHALL size in_port and all per-channel registers.
REQ-002 Parameter DB_W, 16, debounce counter width in bits, legal range 1..16.
REQ-003 Parameter DB_RESET, 0, reset value of the debounce limit register.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  raw asynchronous button/switch inputs.
REQ-011 readdata  output  32  registered read data, zero-extended above the field width.
REQ-012 irq  output  1  level interrupt, OR of (edge_capture AND irq_mask).

Function
REQ-013 Register map SHALL be: 0 debounced data (RO); 1 synchronized raw data (RO); 2 irq_mask (RW); 3 edge_capture (R, write-1-to-clear); 4 rise_en (RW); 5 fall_en (RW); 6 db_limit (RW, DB_W bits); 7 reads 0, writes ignored.
REQ-014 Writes SHALL take effect when chipselect=1 and write_n=0 on a rising clk edge, with writedata LSBs used and upper bits ignored.
REQ-015 readdata SHALL be updated every cycle from address, giving one-cycle read latency independent of chipselect.
REQ-016 Each in_port bit SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-017 Per channel, if s2 equals the debounced state: counter cleared to 0.
REQ-018 Per channel, if s2 differs from the debounced state and counter equals db_limit: debounced state takes s2 and counter clears.
REQ-019 Per channel, otherwise: counter increments by 1.
REQ-020 With db_limit=0 the debounced state SHALL follow s2 one cycle later; total in_port-to-data latency SHALL be db_limit+3 cycles for a stable input.
REQ-021 A glitch shorter than db_limit+1 consecutive cycles at s2 SHALL produce no debounced change.
REQ-022 Writing db_limit mid-count SHALL apply the new limit from the next cycle; a counter already above the new limit SHALL commit on its next mismatching cycle (compare uses counter >= db_limit).
REQ-023 Rising event = debounced state 0->1 AND rise_en bit; falling event = 1->0 AND fall_en bit; both enables set gives any-edge.
REQ-024 An event SHALL set the edge_capture bit on the same edge the debounced state changes.
REQ-025 A write-1 to address 3 SHALL clear the selected edge_capture bits; bits written 0 SHALL be unchanged.
REQ-026 A simultaneous clear and new event on the same bit SHALL leave the bit set (event never lost).
REQ-027 irq SHALL be combinational from edge_capture and irq_mask registers, with no additional latency.

Reset
REQ-028 On reset_n low, asynchronously: synchronizers, debounced state, counters, irq_mask, edge_capture, rise_en, readdata SHALL be 0; fall_en SHALL be 0; db_limit SHALL be DB_RESET; irq SHALL be 0.
REQ-029 An input held high through reset release SHALL produce a rising event after db_limit+3 cycles if rise_en has been set by then.

Structure
REQ-030 Register offsets (0..7) and the DB_W maximum SHALL live in shared package systema_pio_pkg.
REQ-031 One sub-module, systema_debounce_ch (synchronizer, counter, debounced state, rise/fall pulses), SHALL be instantiated WIDTH times by generate.

Verification
REQ-032 Set db_limit=4, rise_en=0xF, hold in_port[0]=1 -> data[0]=1 and edge_capture=0x1 exactly 7 cycles after in_port change.
REQ-033 db_limit=4, in_port[1] pulse of 3 cycles -> data and edge_capture stay 0x0.
REQ-034 fall_en=0x4, irq_mask=0x4, in_port[2] 1->0 debounced -> irq=1; write 0x4 to address 3 -> irq=0 next cycle.
REQ-035 Write-1-clear to bit 0 on the same cycle bit 0 sets -> edge_capture[0] reads 1.
REQ-036 Assert reset_n low mid-count with in_port=0xF -> all registers 0, db_limit=DB_RESET, irq=0 immediately; no spurious event after release with rise_en=0.
